triangle_decoder: RTL and testbench

- Receive-side counterpart of the team's triangular-impulse generator.
- Samples the generator's 8-bit `out` waveform and reconstructs each impulse's direction and step count.
- Delivers each result to a downstream consumer over the same dav_/rfd handshake, with the decoder acting as the producer.
- Malformed impulses are reported as errors. Impulses that arrive while a result is still pending are flagged as overrun.

---
 rtl/triangle_decoder.sv | 179 +++++++++++++++++
 tb/tb_triangle_decoder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_decoder.sv
// triangle_decoder: recovers direction and step count of triangular impulses
// sampled from an 8-bit waveform, and hands each result to a consumer over a
// dav_/rfd handshake. Malformed impulses are flagged via err; impulses that
// start while a result is still pending set the sticky ovr flag.
module triangle_decoder #(
  parameter logic [7:0]  BASE = 8'h80,
  parameter int unsigned NMAX = 127
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in,
  input  logic       rfd,
  output logic       dav_,
  output logic       s_out,
  output logic [6:0] n_out,
  output logic       err,
  output logic       ovr
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 7;

  localparam logic [DATA_W-1:0] BASE_UP = BASE + 8'd1;
  localparam logic [DATA_W-1:0] BASE_DN = BASE - 8'd1;
  localparam logic [CNT_W-1:0]  NMAX_C  = CNT_W'(NMAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAMP,
    S_SKIP,
    S_WAIT_RFD,
    S_DAV
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_prev;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_dir;
  logic                r_errf;
  logic                r_dav_n;
  logic                r_s;
  logic [CNT_W-1:0]    r_n;
  logic                r_err;
  logic                r_ovr;

  state_t              w_state_nxt;
  logic [DATA_W-1:0]   w_prev_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_dir_nxt;
  logic                w_errf_nxt;
  logic                w_dav_n_nxt;
  logic                w_s_nxt;
  logic [CNT_W-1:0]    w_n_nxt;
  logic                w_err_nxt;
  logic                w_ovr_nxt;

  logic [DATA_W-1:0]   w_prev_inc;
  logic [DATA_W-1:0]   w_prev_dec;
  logic                w_step_ok;

  // A legal step continues the ramp by exactly one without wrapping past 0x00/0xFF
  assign w_prev_inc = r_prev + 8'd1;
  assign w_prev_dec = r_prev - 8'd1;
  assign w_step_ok  = r_dir ? ((r_prev != 8'h00) && (in == w_prev_dec))
                            : ((r_prev != 8'hFF) && (in == w_prev_inc));

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_prev  <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_errf  <= 1'b0;
      r_dav_n <= 1'b1;
      r_s     <= 1'b0;
      r_n     <= '0;
      r_err   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_prev  <= w_prev_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_errf  <= w_errf_nxt;
      r_dav_n <= w_dav_n_nxt;
      r_s     <= w_s_nxt;
      r_n     <= w_n_nxt;
      r_err   <= w_err_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_prev_nxt  = r_prev;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_errf_nxt  = r_errf;
    w_dav_n_nxt = r_dav_n;
    w_s_nxt     = r_s;
    w_n_nxt     = r_n;
    w_err_nxt   = r_err;
    w_ovr_nxt   = r_ovr;

    unique case (r_state)
      S_IDLE: begin
        if (in == BASE) begin
          w_state_nxt = S_IDLE;
        end else if (in == BASE_UP || in == BASE_DN) begin
          w_dir_nxt   = (in == BASE_DN);
          w_cnt_nxt   = 7'd1;
          w_prev_nxt  = in;
          w_errf_nxt  = 1'b0;
          w_state_nxt = S_RAMP;
        end else begin
          w_errf_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_dir_nxt   = 1'b0;
          w_state_nxt = S_SKIP;
        end
      end

      S_RAMP: begin
        if (in == BASE) begin
          w_s_nxt     = r_dir;
          w_n_nxt     = r_cnt;
          w_err_nxt   = 1'b0;
          w_state_nxt = S_WAIT_RFD;
        end else if (w_step_ok && (r_cnt != NMAX_C)) begin
          w_cnt_nxt   = r_cnt + 7'd1;
          w_prev_nxt  = in;
        end else begin
          // Hold, reversal, jump, wrap or count overflow
          w_errf_nxt  = 1'b1;
          w_n_nxt     = r_cnt;
          w_state_nxt = S_SKIP;
        end
      end

      S_SKIP: begin
        if (in == BASE) begin
          w_s_nxt     = r_dir;
          w_n_nxt     = r_cnt;
          w_err_nxt   = r_errf;
          w_state_nxt = S_WAIT_RFD;
        end
      end

      S_WAIT_RFD: begin
        if (in != BASE) w_ovr_nxt = 1'b1;
        if (rfd) begin
          w_dav_n_nxt = 1'b0;
          w_state_nxt = S_DAV;
        end
      end

      S_DAV: begin
        if (in != BASE) w_ovr_nxt = 1'b1;
        if (!rfd) begin
          w_dav_n_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign dav_  = r_dav_n;
  assign s_out = r_s;
  assign n_out = r_n;
  assign err   = r_err;
  assign ovr   = r_ovr;

endmodule

// File: tb/tb_triangle_decoder.sv
// tb_triangle_decoder: scoreboard bench for triangle_decoder. Stimulus pushes
// the expected result of each impulse; a monitor pops and compares on every
// dav_ falling edge.
module tb_triangle_decoder;

  localparam logic [7:0] BASE = 8'h80;
  localparam int         NMAX = 127;

  typedef struct packed {
    logic       s;
    logic [6:0] n;
    logic       e;
  } res_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] in;
  logic       rfd;
  logic       dav_;
  logic       s_out;
  logic [6:0] n_out;
  logic       err;
  logic       ovr;

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t exp_q[$];
  logic [7:0] body_q[$];
  bit   auto_ack = 1'b1;
  bit   man_rfd  = 1'b0;
  bit   exp_ovr  = 1'b0;

  triangle_decoder #(.BASE(BASE), .NMAX(NMAX)) dut (
    .clock (clock),
    .reset (reset),
    .in    (in),
    .rfd   (rfd),
    .dav_  (dav_),
    .s_out (s_out),
    .n_out (n_out),
    .err   (err),
    .ovr   (ovr)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Decode a whole impulse body (samples between leaving and returning to BASE)
  function automatic res_t model();
    res_t r;
    int   prev, cnt, v, want, first;
    bit   dir;
    r = '0;
    first = int'(body_q[0]);
    if (first == int'(BASE) + 1)      dir = 1'b0;
    else if (first == int'(BASE) - 1) dir = 1'b1;
    else begin
      r.e = 1'b1;
      return r;
    end
    cnt  = 1;
    prev = first;
    r.s  = dir;
    for (int i = 1; i < body_q.size(); i++) begin
      v    = int'(body_q[i]);
      want = dir ? prev - 1 : prev + 1;
      if (v == want && cnt < NMAX) begin
        cnt++;
        prev = v;
      end else begin
        r.n = 7'(cnt);
        r.e = 1'b1;
        return r;
      end
    end
    r.n = 7'(cnt);
    return r;
  endfunction

  task automatic tick_in(input logic [7:0] v);
    in = v;
    @(posedge clock);
    #1;
  endtask

  task automatic send_body();
    foreach (body_q[i]) tick_in(body_q[i]);
    tick_in(BASE);
    exp_q.push_back(model());
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && dav_ === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick_in(BASE);
    end
    check("done_timeout", 32'(ok), 1);
  endtask

  task automatic gen_body();
    int         len, k;
    bit         dir;
    logic [7:0] v;
    body_q.delete();
    dir = 1'($urandom_range(0, 1));
    len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 130))
                                      : int'($urandom_range(1, 12));
    for (int i = 0; i < len; i++)
      body_q.push_back(dir ? 8'(127 - i) : 8'(129 + i));
    if ($urandom_range(0, 3) == 0) begin
      k = int'($urandom_range(0, len - 1));
      v = 8'($urandom_range(0, 255));
      if (v == BASE) v = 8'h55;
      body_q[k] = v;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dav_"}, 32'(dav_), 1);
    check({tag, "_s_out"}, 32'(s_out), 0);
    check({tag, "_n_out"}, 32'(n_out), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_ovr"}, 32'(ovr), 0);
  endtask

  // Consumer: ready while idle, acknowledges dav_ one cycle after seeing it
  initial begin
    rfd = 1'b1;
    forever begin
      @(negedge clock);
      if (auto_ack) rfd = dav_;
      else          rfd = man_rfd;
    end
  end

  // Monitor: compare each presented result against the scoreboard
  initial begin
    logic pd;
    res_t e;
    pd = 1'b1;
    forever begin
      @(negedge clock);
      if (pd === 1'b1 && dav_ === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got n_out=%0d with no result expected", n_out);
        end else begin
          e = exp_q.pop_front();
          check("s_out", 32'(s_out), 32'(e.s));
          check("n_out", 32'(n_out), 32'(e.n));
          check("err", 32'(err), 32'(e.e));
          check("ovr", 32'(ovr), 32'(exp_ovr));
        end
      end
      pd = dav_;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in    = BASE;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    tick_in(BASE);

    // Rising n=3 with latency checks
    body_q = '{8'h81, 8'h82, 8'h83};
    send_body();
    check("lat_first_base", 32'(dav_), 1);
    @(posedge clock); #1;
    check("lat_dav_fall", 32'(dav_), 0);
    @(posedge clock); #1;
    check("lat_dav_rise", 32'(dav_), 1);
    wait_done();

    // Falling n=5
    body_q = '{8'h7F, 8'h7E, 8'h7D, 8'h7C, 8'h7B};
    send_body();
    wait_done();

    // Full 127-step rising ramp
    body_q.delete();
    for (int k = 0; k < 127; k++) body_q.push_back(8'(129 + k));
    send_body();
    wait_done();

    // Reversal, jump, falling overflow past 0x00
    body_q = '{8'h81, 8'h82, 8'h81};
    send_body();
    wait_done();
    body_q = '{8'h84};
    send_body();
    wait_done();
    body_q.delete();
    for (int k = 0; k < 128; k++) body_q.push_back(8'(127 - k));
    body_q.push_back(8'hFF);
    send_body();
    wait_done();

    // Back-to-back with 3 idle cycles between
    body_q = '{8'h81, 8'h82, 8'h83, 8'h84};
    send_body();
    repeat (3) tick_in(BASE);
    body_q = '{8'h7F, 8'h7E, 8'h7D, 8'h7C, 8'h7B, 8'h7A};
    send_body();
    wait_done();
    check("b2b_ovr", 32'(ovr), 0);

    // Randomized impulses
    for (int t = 0; t < 25; t++) begin
      gen_body();
      send_body();
      wait_done();
      repeat ($urandom_range(0, 2)) tick_in(BASE);
    end

    // Handshake stall with overrun pulses
    auto_ack = 1'b0;
    man_rfd  = 1'b0;
    tick_in(BASE);
    body_q = '{8'h81, 8'h82};
    send_body();
    for (int i = 0; i < 10; i++) begin
      tick_in((i % 2 == 0) ? 8'h81 : BASE);
      check("stall_dav_", 32'(dav_), 1);
    end
    check("stall_ovr", 32'(ovr), 1);
    exp_ovr  = 1'b1;
    auto_ack = 1'b1;
    wait_done();

    // Reset mid-ramp
    tick_in(8'h81);
    tick_in(8'h82);
    reset = 1'b1;
    tick_in(8'h83);
    check_reset_outputs("rst_ramp");
    exp_ovr = 1'b0;
    reset   = 1'b0;
    tick_in(BASE);

    // Reset mid-DAV
    auto_ack = 1'b0;
    man_rfd  = 1'b1;
    tick_in(BASE);
    body_q = '{8'h81};
    send_body();
    tick_in(BASE);
    check("dav_low_before_reset", 32'(dav_), 0);
    reset = 1'b1;
    tick_in(BASE);
    check_reset_outputs("rst_dav");
    reset    = 1'b0;
    auto_ack = 1'b1;
    tick_in(BASE);
    tick_in(BASE);

    // Clean impulse after reset
    body_q = '{8'h81};
    send_body();
    wait_done();

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
